// File: rtl/man_frame_tx.sv
// man_frame_tx: ISO14443A PICC->PCD frame serializer feeding the Manchester encoder.
//
// Builds a frame from a valid/ready byte stream: SOF bit (1), then each byte
// LSB-first followed by its odd parity bit, then a guard gap with the encoder
// disabled. Every bit is held for ETU_CLKS clocks, and enable only toggles on
// ETU boundaries so the encoder's half-ETU timing stays aligned.
//
// Optional build macro: MAN_TX_CRC_EN appends CRC_A (init 0x6363, reflected
// poly 0x8408) as two extra parity-protected bytes, low byte first.
//
// Ports:
//   clk          in   clock (fc/16), rising edge
//   rst          in   synchronous reset, active-high
//   in_start     in   1-cycle frame start pulse, honoured only when idle
//   in_byte      in   data byte
//   in_valid     in   in_byte/in_last valid
//   in_last      in   current byte is the final data byte
//   in_ready     out  byte taken this cycle when in_valid & in_ready
//   out_enable   out  encoder enable, high for the modulated frame
//   out_data     out  encoder data bit, constant for an ETU
//   busy         out  frame in progress
//   done         out  1-cycle pulse, frame completed
//   err_underrun out  1-cycle pulse, frame aborted (no byte at a ready slot)
module man_frame_tx #(
    parameter int ETU_CLKS   = 8,   // clocks per bit, >= 2
    parameter int GUARD_ETUS = 1    // ETUs with enable low before done, >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_start,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_enable,
    output logic       out_data,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);
    localparam int CW = (ETU_CLKS > 2) ? $clog2(ETU_CLKS) : 1;
    localparam int GW = (GUARD_ETUS > 2) ? $clog2(GUARD_ETUS) : 1;

    typedef enum logic [2:0] {IDLE, SOF, DATA, PAR, GUARD} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic [GW-1:0] grd_q, grd_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          etu_end;
`ifdef MAN_TX_CRC_EN
    logic [15:0]   crc_q, crc_d;
    logic [1:0]    crcph_q, crcph_d;  // 0: data bytes, 1: CRC low, 2: CRC high
    logic          crc_fb;
`endif

    assign etu_end = (cnt_q == CW'(ETU_CLKS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            grd_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MAN_TX_CRC_EN
            crc_q   <= 16'h6363;
            crcph_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            grd_q   <= grd_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MAN_TX_CRC_EN
            crc_q   <= crc_d;
            crcph_q <= crcph_d;
`endif
        end
    end

    // Next-state logic. Every exit from a busy state happens at etu_end, so
    // the counter is already back at 0 whenever IDLE is re-entered.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        last_d  = last_q;
        grd_d   = grd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = (state_q == IDLE || etu_end) ? '0 : cnt_q + 1'b1;
`ifdef MAN_TX_CRC_EN
        crc_d   = crc_q;
        crcph_d = crcph_q;
        crc_fb  = crc_q[0] ^ byte_q[bit_q];
`endif
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d = SOF;
`ifdef MAN_TX_CRC_EN
                    crc_d   = 16'h6363;
                    crcph_d = '0;
`endif
                end
            end
            SOF: begin
                if (etu_end) begin
                    if (in_valid) begin
                        state_d = DATA;
                        byte_d  = in_byte;
                        last_d  = in_last;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (etu_end) begin
`ifdef MAN_TX_CRC_EN
                    // CRC covers data bits only, not the appended CRC bytes
                    if (crcph_q == 2'd0)
                        crc_d = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'h8408 : 16'h0000);
`endif
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PAR;
                end
            end
            PAR: begin
                if (etu_end) begin
                    if (!last_q) begin
                        if (in_valid) begin
                            state_d = DATA;
                            byte_d  = in_byte;
                            last_d  = in_last;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
`ifdef MAN_TX_CRC_EN
                        // last_q stays set, so CRC bytes never raise in_ready
                        if (crcph_q == 2'd0) begin
                            state_d = DATA;
                            byte_d  = crc_q[7:0];
                            bit_d   = '0;
                            crcph_d = 2'd1;
                        end else if (crcph_q == 2'd1) begin
                            state_d = DATA;
                            byte_d  = crc_q[15:8];
                            bit_d   = '0;
                            crcph_d = 2'd2;
                        end else begin
                            state_d = GUARD;
                            grd_d   = '0;
                        end
`else
                        state_d = GUARD;
                        grd_d   = '0;
`endif
                    end
                end
            end
            GUARD: begin
                if (etu_end) begin
                    if (grd_q == GW'(GUARD_ETUS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        grd_d = grd_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        out_enable   = 1'b0;
        out_data     = 1'b0;
        in_ready     = 1'b0;
        busy         = (state_q != IDLE);
        done         = done_q;
        err_underrun = err_q;
        case (state_q)
            SOF: begin
                out_enable = 1'b1;
                out_data   = 1'b1;
                in_ready   = etu_end;
            end
            DATA: begin
                out_enable = 1'b1;
                out_data   = byte_q[bit_q];
            end
            PAR: begin
                out_enable = 1'b1;
                out_data   = ~^byte_q;
                in_ready   = etu_end & ~last_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_man_frame_tx.sv
`timescale 1ns/1ps
module tb_man_frame_tx;
    localparam int ETU = 8;
    localparam int GRD = 1;
`ifdef MAN_TX_CRC_EN
    localparam int NCRC = 2;
`else
    localparam int NCRC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_start, in_valid, in_last;
    logic [7:0] in_byte;
    logic       in_ready, out_enable, out_data, busy, done, err_underrun;

    man_frame_tx #(.ETU_CLKS(ETU), .GUARD_ETUS(GRD)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_byte(in_byte),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_enable(out_enable), .out_data(out_data), .busy(busy),
        .done(done), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];          // expected bit per enabled ETU

    // Monitor: captures out_data at the first cycle of each enabled ETU
    int   en_cnt = 0, got_n = 0, unstable = 0, etu_pos = 0;
    logic got_bits [0:8191];
    logic cur_bit = 1'b0;
    always @(negedge clk) begin
        if (out_enable === 1'b1) begin
            if (etu_pos == 0) begin
                got_bits[got_n] <= out_data;
                got_n   <= got_n + 1;
                cur_bit <= out_data;
            end else if (out_data !== cur_bit) begin
                unstable <= unstable + 1;
            end
            etu_pos <= (etu_pos == ETU - 1) ? 0 : etu_pos + 1;
            en_cnt  <= en_cnt + 1;
        end else begin
            etu_pos <= 0;
        end
    end

    logic [7:0] tx [0:3];
    int r_first_ready, r_last_ready, r_ready_cnt, r_done_k, r_err_k;
    int r_done_cnt, r_err_cnt, r_last_en;
    bit r_busy_end, r_en_err, r_busy_post, r_to;

    function automatic logic [15:0] crc_a(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'h6363;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ tx[i][b];
                c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
            end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
    endtask

    // Drives one frame of n bytes from tx[], supplying only 'supply' of them,
    // and records handshake/pulse timing; k=1 is the first cycle after start.
    task automatic drive_frame(input int n, input int supply, input int mid_start_k);
        int k, bi, post;
        bit adv, seen;
        logic [15:0] c;
        exp_q.push_back(1'b1);
        for (int i = 0; i < supply; i++) push_byte(tx[i]);
        if (supply == n && NCRC != 0) begin
            c = crc_a(n);
            push_byte(c[7:0]);
            push_byte(c[15:8]);
        end
        r_first_ready = 0; r_last_ready = 0; r_ready_cnt = 0; r_done_k = 0; r_err_k = 0;
        r_done_cnt = 0; r_err_cnt = 0; r_last_en = 0;
        r_busy_end = 1'b1; r_en_err = 1'b1; r_busy_post = 1'b0;
        in_byte = tx[0]; in_last = (n == 1); in_valid = (supply > 0);
        @(posedge clk); #1 in_start = 1'b1;
        @(posedge clk); #1 in_start = 1'b0;
        k = 0; bi = 0; adv = 0; seen = 0; post = 0;
        while (post < 3 && k < 2000) begin
            @(negedge clk); k++;
            in_start = (k == mid_start_k);
            if (adv) begin
                adv = 0; bi++;
                if (bi < supply) begin in_byte = tx[bi]; in_last = (bi == n - 1); end
                else in_valid = 1'b0;
            end
            if (in_ready) begin
                r_ready_cnt++;
                if (r_first_ready == 0) r_first_ready = k;
                r_last_ready = k;
                if (in_valid) adv = 1;
            end
            if (out_enable) r_last_en = k;
            if (done) begin r_done_cnt++; r_done_k = k; r_busy_end = busy; end
            if (err_underrun) begin r_err_cnt++; r_err_k = k; r_busy_end = busy; r_en_err = out_enable; end
            if (seen) begin post++; if (busy) r_busy_post = 1'b1; end
            else if (done || err_underrun) begin seen = 1; post = 1; end
        end
        in_start = 1'b0; in_valid = 1'b0;
        r_to = !seen;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_start = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({out_enable, out_data, in_ready, busy, done, err_underrun} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000",
                {out_enable, out_data, in_ready, busy, done, err_underrun});
        end
        in_start = 1'b1;                 // coincides with reset: must be dropped
        @(posedge clk); #1 rst = 1'b0; in_start = 1'b0;
        n_checks++; if (busy !== 1'b0 || out_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_start_same_edge: busy=%b en=%b want 0 0", busy, out_enable);
        end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_still_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_byte(input logic [7:0] b);
        int e0, g0, u0, nb, L;
        bit e;
        tx[0] = b; e0 = en_cnt; g0 = got_n; u0 = unstable;
        L = (1 + 9 * (1 + NCRC)) * ETU;
        drive_frame(1, 1, 0);
        nb = exp_q.size();
        n_checks++; if (r_to) begin n_fail++; $display("FAIL single_%h_timeout: no done/err within budget", b); end
        n_checks++; if (got_n - g0 != nb) begin n_fail++; $display("FAIL single_%h_nbits: got %0d want %0d", b, got_n - g0, nb); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_bits[g0 + i] !== e) begin n_fail++; $display("FAIL single_%h_bit%0d: got %b want %b", b, i, got_bits[g0 + i], e); end
        end
        n_checks++; if (en_cnt - e0 != L) begin n_fail++; $display("FAIL single_%h_en_len: got %0d want %0d", b, en_cnt - e0, L); end
        n_checks++; if (r_last_en != L) begin n_fail++; $display("FAIL single_%h_en_fall: got %0d want %0d", b, r_last_en, L); end
        n_checks++; if (r_first_ready != ETU) begin n_fail++; $display("FAIL single_%h_ready_cycle: got %0d want %0d", b, r_first_ready, ETU); end
        n_checks++; if (r_ready_cnt != 1) begin n_fail++; $display("FAIL single_%h_ready_cnt: got %0d want 1", b, r_ready_cnt); end
        n_checks++; if (r_done_k != L + GRD * ETU + 1) begin n_fail++; $display("FAIL single_%h_done_cycle: got %0d want %0d", b, r_done_k, L + GRD * ETU + 1); end
        n_checks++; if (r_done_cnt != 1 || r_err_cnt != 0) begin n_fail++; $display("FAIL single_%h_pulses: done=%0d err=%0d want 1 0", b, r_done_cnt, r_err_cnt); end
        n_checks++; if (r_busy_end !== 1'b0) begin n_fail++; $display("FAIL single_%h_busy_at_done: got %b want 0", b, r_busy_end); end
        n_checks++; if (unstable - u0 != 0) begin n_fail++; $display("FAIL single_%h_mid_etu_change: got %0d want 0", b, unstable - u0); end
    endtask

    task automatic test_two_bytes;
        int e0, g0, L;
        bit e;
        tx[0] = 8'hA5; tx[1] = 8'hFF; e0 = en_cnt; g0 = got_n;
        L = (1 + 9 * (2 + NCRC)) * ETU;
        drive_frame(2, 2, 0);
        n_checks++; if (r_to) begin n_fail++; $display("FAIL two_timeout: no done within budget"); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_bits[g0 + i] !== e) begin n_fail++; $display("FAIL two_bit%0d: got %b want %b", i, got_bits[g0 + i], e); end
        end
        n_checks++; if (en_cnt - e0 != L) begin n_fail++; $display("FAIL two_en_len: got %0d want %0d", en_cnt - e0, L); end
        n_checks++; if (r_last_ready != 10 * ETU) begin n_fail++; $display("FAIL two_second_ready: got %0d want %0d", r_last_ready, 10 * ETU); end
        n_checks++; if (r_ready_cnt != 2) begin n_fail++; $display("FAIL two_ready_cnt: got %0d want 2", r_ready_cnt); end
        n_checks++; if (r_done_k != L + GRD * ETU + 1 || r_done_cnt != 1) begin
            n_fail++; $display("FAIL two_done: cycle %0d count %0d want %0d 1", r_done_k, r_done_cnt, L + GRD * ETU + 1); end
    endtask

    task automatic test_underrun;
        int e0, g0;
        bit e;
        tx[0] = 8'h3C; tx[1] = 8'h99; e0 = en_cnt; g0 = got_n;
        drive_frame(2, 1, 0);
        n_checks++; if (r_to) begin n_fail++; $display("FAIL underrun_timeout: no err within budget"); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_bits[g0 + i] !== e) begin n_fail++; $display("FAIL underrun_bit%0d: got %b want %b", i, got_bits[g0 + i], e); end
        end
        n_checks++; if (r_last_ready != 10 * ETU) begin n_fail++; $display("FAIL underrun_boundary: got %0d want %0d", r_last_ready, 10 * ETU); end
        n_checks++; if (r_err_k != 10 * ETU + 1) begin n_fail++; $display("FAIL underrun_err_cycle: got %0d want %0d", r_err_k, 10 * ETU + 1); end
        n_checks++; if (r_err_cnt != 1 || r_done_cnt != 0) begin n_fail++; $display("FAIL underrun_pulses: err=%0d done=%0d want 1 0", r_err_cnt, r_done_cnt); end
        n_checks++; if (r_en_err !== 1'b0 || r_busy_end !== 1'b0) begin n_fail++; $display("FAIL underrun_outputs: en=%b busy=%b want 0 0", r_en_err, r_busy_end); end
        n_checks++; if (en_cnt - e0 != 10 * ETU) begin n_fail++; $display("FAIL underrun_en_len: got %0d want %0d", en_cnt - e0, 10 * ETU); end
        test_single_byte(8'h81);         // a fresh frame must work right after the abort
    endtask

    task automatic test_start_ignored;
        int g0;
        bit e;
        tx[0] = 8'h3C; tx[1] = 8'h5A; g0 = got_n;
        drive_frame(2, 2, 5 * ETU);      // extra in_start mid-DATA
        n_checks++; if (r_to) begin n_fail++; $display("FAIL ignore_timeout: no done within budget"); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); n_checks++;
            if (got_bits[g0 + i] !== e) begin n_fail++; $display("FAIL ignore_bit%0d: got %b want %b", i, got_bits[g0 + i], e); end
        end
        n_checks++; if (r_done_cnt != 1 || r_busy_post !== 1'b0) begin
            n_fail++; $display("FAIL ignore_restart: done=%0d busy_after=%b want 1 0", r_done_cnt, r_busy_post); end
    endtask

    task automatic test_reset_mid;
        int e0, k;
        e0 = en_cnt;
        in_byte = 8'h5A; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_start = 1'b1;
        @(posedge clk); #1 in_start = 1'b0;
        k = 0;
        while (en_cnt - e0 < 5 * ETU + 3 && k < 500) begin @(negedge clk); k++; end
        n_checks++; if (k >= 500) begin n_fail++; $display("FAIL rstmid_timeout: frame never reached bit 4"); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({out_enable, out_data, in_ready, busy, done, err_underrun} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b want 000000",
                {out_enable, out_data, in_ready, busy, done, err_underrun});
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || out_enable !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_resume: busy=%b en=%b done=%b want 0 0 0", busy, out_enable, done); end
    endtask

`ifdef MAN_TX_CRC_EN
    task automatic test_crc;
        logic [7:0] din [0:3];
        logic [7:0] cexp [0:3];
        logic [7:0] glo, ghi;
        int g0, e0;
        bit e;
        din[0] = 8'h00; din[1] = 8'h00; cexp[0] = 8'hA0; cexp[1] = 8'h1E;
        din[2] = 8'h12; din[3] = 8'h34; cexp[2] = 8'h26; cexp[3] = 8'hCF;
        for (int t = 0; t < 2; t++) begin
            tx[0] = din[2 * t]; tx[1] = din[2 * t + 1]; g0 = got_n; e0 = en_cnt;
            drive_frame(2, 2, 0);
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front(); n_checks++;
                if (got_bits[g0 + i] !== e) begin n_fail++; $display("FAIL crc%0d_bit%0d: got %b want %b", t, i, got_bits[g0 + i], e); end
            end
            for (int b = 0; b < 8; b++) begin
                glo[b] = got_bits[g0 + 19 + b];
                ghi[b] = got_bits[g0 + 28 + b];
            end
            n_checks++; if (glo !== cexp[2 * t]) begin n_fail++; $display("FAIL crc%0d_low: got %h want %h", t, glo, cexp[2 * t]); end
            n_checks++; if (ghi !== cexp[2 * t + 1]) begin n_fail++; $display("FAIL crc%0d_high: got %h want %h", t, ghi, cexp[2 * t + 1]); end
            n_checks++; if (en_cnt - e0 != 37 * ETU) begin n_fail++; $display("FAIL crc%0d_en_len: got %0d want %0d", t, en_cnt - e0, 37 * ETU); end
            n_checks++; if (r_ready_cnt != 2 || r_done_cnt != 1) begin
                n_fail++; $display("FAIL crc%0d_handshake: ready=%0d done=%0d want 2 1", t, r_ready_cnt, r_done_cnt); end
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte(8'h01);
        test_single_byte(8'h00);
        test_two_bytes();
        test_underrun();
        test_start_ignored();
        test_reset_mid();
`ifdef MAN_TX_CRC_EN
        test_crc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
